// File: rtl/hc595_shift_driver.sv
// Serialises a 16-bit {seg,sel} word into two chained 74HC595s and then latches it.
// A frame starts on din_vld, on a queued request, or on the periodic refresh timer.
// Define SEG595_LSB_FIRST_EN to shift din[0] out first instead of din[15].
module hc595_shift_driver #(
    parameter int CLK_DIV     = 2,
    parameter int REFRESH_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_vld,
    output logic        ds,
    output logic        shcp,
    output logic        stcp,
    output logic        oe_n,
    output logic        busy
);

    localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
    localparam int REF_W = $clog2(REFRESH_CYC + 1);

    localparam logic [DIV_W-1:0] DIV_LO_END = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HI_END = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [REF_W-1:0] REF_END    = REF_W'(REFRESH_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]       r_state;
    logic [15:0]      r_shreg;
    logic [3:0]       r_bit_cnt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [REF_W-1:0] r_ref_cnt;
    logic             r_pending;
    logic             r_ds;
    logic             r_shcp;
    logic             r_stcp;
    logic             r_oe_n;
    logic             r_busy;

    logic             w_start;
    logic             w_bit_end;
    logic [15:0]      w_shreg_nxt;
    logic             w_first_bit;
    logic             w_next_bit;

    assign w_start   = (r_state == S_IDLE) &&
                       (din_vld || r_pending || (r_ref_cnt == REF_END));
    assign w_bit_end = (r_state == S_SHIFT) && (r_div_cnt == DIV_HI_END);

`ifdef SEG595_LSB_FIRST_EN
    assign w_shreg_nxt = r_shreg >> 1;
    assign w_first_bit = din[0];
    assign w_next_bit  = w_shreg_nxt[0];
`else
    assign w_shreg_nxt = r_shreg << 1;
    assign w_first_bit = din[15];
    assign w_next_bit  = w_shreg_nxt[15];
`endif

    // Data word: loaded only on the start cycle, so din may change freely mid-frame.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_shreg <= din;
        end else if (w_bit_end) begin
            r_shreg <= w_shreg_nxt;
        end
    end

    // Refresh timer and request queue; several requests during a frame collapse into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_start) begin
                r_ref_cnt <= '0;
            end else if (r_ref_cnt != REF_END) begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
            r_pending <= (r_state != S_IDLE) ? (r_pending | din_vld) : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_ds      <= 1'b0;
            r_shcp    <= 1'b0;
            r_stcp    <= 1'b0;
            r_oe_n    <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_SHIFT;
                        r_busy    <= 1'b1;
                        r_ds      <= w_first_bit;
                        r_bit_cnt <= '0;
                        r_div_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (r_div_cnt == DIV_HI_END) begin
                        r_div_cnt <= '0;
                        r_shcp    <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd15) begin
                            r_state <= S_LATCH;
                            r_ds    <= 1'b0;
                            r_stcp  <= 1'b1;
                        end else begin
                            r_ds <= w_next_bit;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                        if (r_div_cnt == DIV_LO_END) begin
                            r_shcp <= 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    // Outputs stay blanked until a complete word has been latched once.
                    if (r_div_cnt == DIV_LO_END) begin
                        r_div_cnt <= '0;
                        r_stcp    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_oe_n    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ds   = r_ds;
    assign shcp = r_shcp;
    assign stcp = r_stcp;
    assign oe_n = r_oe_n;
    assign busy = r_busy;

endmodule
